// File: rtl/alu_shl_result_buffer.sv
// alu_shl_result_buffer
//   Sits after the N-bit shift-left ALU. Each accepted transaction (a, b, r)
//   is checked against a reference shift. The captured r and its status flags
//   are queued in a small FIFO that is drained by a valid/ready consumer.
//   A saturating counter tracks how many accepted results were wrong.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake; in_ready depends on occupancy only
//   a, b, r           operand, shift amount (b[1:0] used), shifter result
//   out_valid/out_ready  consumer handshake for the head entry
//   out_r, out_zero, out_lost, out_err  head entry; all 0 while empty
//   count             occupancy, 0..DEPTH
//   err_cnt           saturating count of accepted mismatches
module alu_shl_result_buffer #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4,
   parameter int ERRW  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         a,
   input  logic [WIDTH-1:0]         b,
   input  logic [WIDTH-1:0]         r,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_r,
   output logic                     out_zero,
   output logic                     out_lost,
   output logic                     out_err,
   output logic [$clog2(DEPTH):0]   count,
   output logic [ERRW-1:0]          err_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // ------------------------------------------------------------------
   // Reference shift and flags, evaluated on the incoming transaction.
   // a is widened by 3 bits so the bits shifted past WIDTH land in the top
   // field; OR-ing that field is exactly "some 1 bit was discarded". With a
   // 2-bit shift amount this also covers sh >= WIDTH (expected = 0, lost = |a).
   // ------------------------------------------------------------------
   logic [1:0]        sh;
   logic [WIDTH+2:0]  ext;
   logic [WIDTH-1:0]  expected;
   logic              in_zero, in_lost, in_err;
   logic              unused_b;

   assign sh       = b[1:0];
   assign ext      = {3'b000, a} << sh;
   assign expected = ext[WIDTH-1:0];
   assign in_lost  = |ext[WIDTH+2:WIDTH];
   assign in_zero  = (r == '0);
   assign in_err   = (r != expected);
   assign unused_b = ^b;

   // ------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          push, pop;

   // Full never accepts, even when the head is popping this cycle.
   assign in_ready  = (count < CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         err_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (push && in_err && (err_cnt != '1))
            err_cnt <= err_cnt + ERRW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Storage; contents need no reset because outputs are gated by count.
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [DEPTH-1:0] mem_zero, mem_lost, mem_err;

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_r[wr_ptr]    <= r;
         mem_zero[wr_ptr] <= in_zero;
         mem_lost[wr_ptr] <= in_lost;
         mem_err[wr_ptr]  <= in_err;
      end
   end

   assign out_r    = out_valid ? mem_r[rd_ptr]    : '0;
   assign out_zero = out_valid ? mem_zero[rd_ptr] : 1'b0;
   assign out_lost = out_valid ? mem_lost[rd_ptr] : 1'b0;
   assign out_err  = out_valid ? mem_err[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_alu_shl_result_buffer.sv
// Directed bench for alu_shl_result_buffer. A second instance with ERRW=2
// exercises error-counter saturation.
module tb_alu_shl_result_buffer;

   logic       clk = 0;
   logic       rst;
   logic       in_valid, out_ready;
   logic [2:0] a, b, r;
   logic       in_ready, out_valid, out_zero, out_lost, out_err;
   logic [2:0] out_r;
   logic [2:0] count;
   logic [7:0] err_cnt;

   logic       in_valid2, out_ready2;
   logic [2:0] a2, b2, r2;
   logic       in_ready2, out_valid2, out_zero2, out_lost2, out_err2;
   logic [2:0] out_r2;
   logic [2:0] count2;
   logic [1:0] err_cnt2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_shl_result_buffer #(.WIDTH(3), .DEPTH(4), .ERRW(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .r(r), .out_valid(out_valid), .out_ready(out_ready),
      .out_r(out_r), .out_zero(out_zero), .out_lost(out_lost), .out_err(out_err),
      .count(count), .err_cnt(err_cnt));

   alu_shl_result_buffer #(.WIDTH(3), .DEPTH(4), .ERRW(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .r(r2), .out_valid(out_valid2), .out_ready(out_ready2),
      .out_r(out_r2), .out_zero(out_zero2), .out_lost(out_lost2), .out_err(out_err2),
      .count(count2), .err_cnt(err_cnt2));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; in_valid = 1; a = 3'd7; b = 3'd0; r = 3'd1; out_ready = 0;
      in_valid2 = 0; a2 = 0; b2 = 0; r2 = 0; out_ready2 = 0;
      step(); step();
      tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      tests++; if (count !== 3'd0)     begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
      tests++; if (err_cnt !== 8'd0)   begin fails++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
      tests++; if ({out_r, out_zero, out_lost, out_err} !== 6'b0)
         begin fails++; $display("FAIL reset_out_fields got=%b exp=000000", {out_r, out_zero, out_lost, out_err}); end
      tests++; if ({count2, err_cnt2, out_valid2} !== 6'b0)
         begin fails++; $display("FAIL reset_dut2 got=%b exp=000000", {count2, err_cnt2, out_valid2}); end
      rst = 0; in_valid = 0;
      step();
      tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_data_discarded count got=%0d exp=0", count); end
   endtask

   task automatic test_single();
      in_valid = 1; a = 3'b011; b = 3'd1; r = 3'b110; out_ready = 0;
      step();
      in_valid = 0;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_out_valid got=%0b exp=1", out_valid); end
      tests++; if (out_r !== 3'b110)   begin fails++; $display("FAIL single_out_r got=%b exp=110", out_r); end
      tests++; if ({out_zero, out_lost, out_err} !== 3'b000)
         begin fails++; $display("FAIL single_flags got=%b exp=000", {out_zero, out_lost, out_err}); end
      tests++; if (count !== 3'd1) begin fails++; $display("FAIL single_count got=%0d exp=1", count); end
      out_ready = 1;
      step();
      out_ready = 0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_pop_out_valid got=%0b exp=0", out_valid); end
      tests++; if (out_r !== 3'b000)   begin fails++; $display("FAIL single_empty_out_r got=%b exp=000", out_r); end
   endtask

   task automatic test_flags();
      logic [2:0] er [3];
      logic [2:0] ef [3];   // {zero, lost, err}
      er[0] = 3'b100; ef[0] = 3'b010;
      er[1] = 3'b000; ef[1] = 3'b110;
      er[2] = 3'b111; ef[2] = 3'b001;
      out_ready = 0; in_valid = 1;
      a = 3'b101; b = 3'd2; r = 3'b100; step();
      a = 3'b001; b = 3'd3; r = 3'b000; step();
      a = 3'b011; b = 3'd1; r = 3'b111; step();
      in_valid = 0;
      tests++; if (count !== 3'd3)   begin fails++; $display("FAIL flags_count got=%0d exp=3", count); end
      tests++; if (err_cnt !== 8'd1) begin fails++; $display("FAIL flags_err_cnt got=%0d exp=1", err_cnt); end
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         tests++; if (out_r !== er[i])
            begin fails++; $display("FAIL flags_order_r[%0d] got=%b exp=%b", i, out_r, er[i]); end
         tests++; if ({out_zero, out_lost, out_err} !== ef[i])
            begin fails++; $display("FAIL flags_zle[%0d] got=%b exp=%b", i, {out_zero, out_lost, out_err}, ef[i]); end
         step();
      end
      out_ready = 0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flags_drained got=%0b exp=0", out_valid); end
      // Pop while empty must not disturb anything.
      out_ready = 1; step(); out_ready = 0;
      tests++; if (count !== 3'd0) begin fails++; $display("FAIL empty_pop_count got=%0d exp=0", count); end
   endtask

   task automatic test_fill_wrap();
      logic [2:0] v;
      out_ready = 0; b = 3'd0;
      for (int i = 1; i <= 4; i++) begin
         v = 3'(i); in_valid = 1; a = v; r = v;
         step();
         tests++; if (count !== 3'(i)) begin fails++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
         tests++; if (in_ready !== (i < 4)) begin fails++; $display("FAIL fill_in_ready[%0d] got=%0b exp=%0b", i, in_ready, i < 4); end
      end
      a = 3'd5; r = 3'd5;
      step();
      tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_hold_count got=%0d exp=4", count); end
      // Pop at full with push pending: only the pop happens.
      out_ready = 1;
      step();
      tests++; if (count !== 3'd3)   begin fails++; $display("FAIL full_pop_count got=%0d exp=3", count); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_pop_in_ready got=%0b exp=1", in_ready); end
      tests++; if (out_r !== 3'd2)   begin fails++; $display("FAIL full_pop_head got=%0d exp=2", out_r); end
      out_ready = 0;
      step();
      in_valid = 0;
      tests++; if (count !== 3'd4) begin fails++; $display("FAIL held_accept_count got=%0d exp=4", count); end
      out_ready = 1;
      for (int k = 2; k <= 5; k++) begin
         tests++; if (out_r !== 3'(k)) begin fails++; $display("FAIL wrap_order[%0d] got=%0d exp=%0d", k, out_r, k); end
         step();
      end
      out_ready = 0;
      tests++; if (count !== 3'd0) begin fails++; $display("FAIL wrap_drain_count got=%0d exp=0", count); end
      // Second lap: push 6,7 then push/pop at count=2.
      in_valid = 1; a = 3'd6; r = 3'd6; step();
      a = 3'd7; r = 3'd7; step();
      a = 3'd0; r = 3'd0; out_ready = 1;
      tests++; if (out_r !== 3'd6) begin fails++; $display("FAIL pp_head0 got=%0d exp=6", out_r); end
      step();
      tests++; if (count !== 3'd2) begin fails++; $display("FAIL pp_count0 got=%0d exp=2", count); end
      tests++; if (out_r !== 3'd7) begin fails++; $display("FAIL pp_head1 got=%0d exp=7", out_r); end
      a = 3'd1; r = 3'd1;
      step();
      in_valid = 0;
      tests++; if (count !== 3'd2) begin fails++; $display("FAIL pp_count1 got=%0d exp=2", count); end
      tests++; if (out_r !== 3'd0) begin fails++; $display("FAIL pp_head2 got=%0d exp=0", out_r); end
      step();
      tests++; if (out_r !== 3'd1) begin fails++; $display("FAIL pp_head3 got=%0d exp=1", out_r); end
      step();
      out_ready = 0; in_valid = 1; a = 3'd2; r = 3'd2;
      step();
      in_valid = 0;
      tests++; if (out_r !== 3'd2 || count !== 3'd1)
         begin fails++; $display("FAIL wrap_tenth got r=%0d cnt=%0d exp r=2 cnt=1", out_r, count); end
      out_ready = 1; step(); out_ready = 0;
      tests++; if (err_cnt !== 8'd1) begin fails++; $display("FAIL fill_err_cnt got=%0d exp=1", err_cnt); end
   endtask

   task automatic test_reset_mid();
      out_ready = 0; in_valid = 1; a = 3'd0; b = 3'd0; r = 3'd1;
      step(); step(); step();
      out_ready = 1;
      step();
      tests++; if (count !== 3'd3)   begin fails++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
      tests++; if (err_cnt !== 8'd5) begin fails++; $display("FAIL mid_pre_err_cnt got=%0d exp=5", err_cnt); end
      rst = 1;
      step();
      tests++; if (count !== 3'd0)     begin fails++; $display("FAIL mid_count got=%0d exp=0", count); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid got=%0b exp=0", out_valid); end
      tests++; if (err_cnt !== 8'd0)   begin fails++; $display("FAIL mid_err_cnt got=%0d exp=0", err_cnt); end
      rst = 0; in_valid = 0; out_ready = 0;
      step();
      tests++; if (count !== 3'd0) begin fails++; $display("FAIL mid_after_count got=%0d exp=0", count); end
   endtask

   task automatic test_saturation();
      logic [1:0] exp;
      in_valid2 = 1; a2 = 3'd0; b2 = 3'd0; r2 = 3'd1; out_ready2 = 1;
      for (int i = 1; i <= 5; i++) begin
         step();
         exp = (i < 3) ? 2'(i) : 2'd3;
         tests++; if (err_cnt2 !== exp) begin fails++; $display("FAIL sat_err_cnt[%0d] got=%0d exp=%0d", i, err_cnt2, exp); end
      end
      in_valid2 = 0;
      step();
      tests++; if (count2 !== 3'd0 || err_cnt2 !== 2'd3)
         begin fails++; $display("FAIL sat_final got cnt=%0d err=%0d exp cnt=0 err=3", count2, err_cnt2); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_flags();
      test_fill_wrap();
      test_reset_mid();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
